// File: rtl/rfphoenix_vec_wb_arbiter.sv
// rfPhoenix vector writeback collector: per-source result FIFOs feeding one round-robin regfile write.
// Optional feature macro RFPHOENIX_WB_BYPASS_EN: a result may skip the FIFO when nothing is queued.

package rfphoenix_vec_wb_pkg;
  localparam int unsigned TID_W  = 4;
  localparam int unsigned REG_W  = 6;
  localparam int unsigned MASK_W = 64;
  localparam int unsigned NLANES = 16;
  localparam int unsigned LANE_W = 32;

  typedef logic [TID_W-1:0] tid_t;
  typedef struct packed {
    logic [REG_W-1:0] num;
  } regspec_t;
  typedef logic [NLANES-1:0][LANE_W-1:0] vector_value_t;

  typedef struct packed {
    tid_t              thread;
    regspec_t          wa;
    logic [MASK_W-1:0] mask;
    vector_value_t     val;
  } wb_entry_t;
endpackage

module rfphoenix_vec_wb_arbiter
  import rfphoenix_vec_wb_pkg::*;
#(
  parameter int unsigned NSRC  = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce,
  input  logic          [NSRC-1:0]       src_v_i,
  output logic          [NSRC-1:0]       src_rdy_o,
  input  tid_t          [NSRC-1:0]       src_thread_i,
  input  regspec_t      [NSRC-1:0]       src_wa_i,
  input  logic          [NSRC-1:0][MASK_W-1:0] src_mask_i,
  input  vector_value_t [NSRC-1:0]       src_val_i,
  output logic                           wr_o,
  output tid_t                           wthread_o,
  output regspec_t                       wa_o,
  output logic          [MASK_W-1:0]     wmask_o,
  output vector_value_t                  o_o,
  output logic          [NSRC-1:0]       pending_o,
  output logic                           idle_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]       full;
  logic [NSRC-1:0]       nonempty;
  logic [NSRC-1:0]       push_req;
  logic [NSRC-1:0]       push;
  logic [NSRC-1:0]       pop;
  wb_entry_t [NSRC-1:0]  in_entry;
  wb_entry_t [NSRC-1:0]  head_ent;

  logic                  grant_v;
  logic                  byp_v;
  logic [PW-1:0]         grant_idx;
  logic [PW-1:0]         rr_q, rr_d, rr_inc;
  wb_entry_t             out_q, out_d;
  logic                  wr_q, wr_d;

  // Per-source FIFO: pointers wrap naturally since DEPTH is a power of two.
  for (genvar s = 0; s < NSRC; s++) begin : g_src
    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    assign in_entry[s]  = '{thread: src_thread_i[s], wa: src_wa_i[s],
                            mask: src_mask_i[s], val: src_val_i[s]};
    assign full[s]      = (count_q == CW'(DEPTH));
    assign nonempty[s]  = (count_q != '0);
    assign pending_o[s] = nonempty[s];
    assign src_rdy_o[s] = ce & ~full[s] & ~rst;
    assign push_req[s]  = src_v_i[s] & src_rdy_o[s];
    assign push[s]      = push_req[s] & ~(byp_v & (grant_idx == PW'(s)));
    assign pop[s]       = ce & grant_v & (grant_idx == PW'(s));
    assign head_ent[s]  = mem_q[head_q];

    always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push[s]) tail_d = tail_q + AW'(1);
      if (pop[s])  head_d = head_q + AW'(1);
      if (push[s] && !pop[s])      count_d = count_q + CW'(1);
      else if (!push[s] && pop[s]) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push[s]) mem_q[tail_q] <= in_entry[s];
    end
  end

  // Round-robin scan from rr_q; queued entries always beat a bypass candidate.
  always_comb begin
    logic [PW:0] idx;
    grant_v   = 1'b0;
    byp_v     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = {1'b0, rr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NSRC)) idx = idx - (PW+1)'(NSRC);
      if (!grant_v && nonempty[idx[PW-1:0]]) begin
        grant_v   = 1'b1;
        grant_idx = idx[PW-1:0];
      end
    end
`ifdef RFPHOENIX_WB_BYPASS_EN
    if (!grant_v) begin
      for (int k = 0; k < NSRC; k++) begin
        idx = {1'b0, rr_q} + (PW+1)'(k);
        if (idx >= (PW+1)'(NSRC)) idx = idx - (PW+1)'(NSRC);
        if (!byp_v && push_req[idx[PW-1:0]]) begin
          byp_v     = 1'b1;
          grant_idx = idx[PW-1:0];
        end
      end
    end
`endif
  end

  assign rr_inc = (grant_idx == PW'(NSRC - 1)) ? '0 : grant_idx + PW'(1);

  // Output stage: a zero-mask entry is consumed as a grant but suppresses the write.
  always_comb begin
    out_d = out_q;
    wr_d  = wr_q;
    rr_d  = rr_q;
    if (ce) begin
      wr_d = 1'b0;
      if (grant_v || byp_v) begin
        out_d = grant_v ? head_ent[grant_idx] : in_entry[grant_idx];
        wr_d  = (out_d.mask != '0);
        rr_d  = rr_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      wr_q  <= 1'b0;
      rr_q  <= '0;
    end else begin
      out_q <= out_d;
      wr_q  <= wr_d;
      rr_q  <= rr_d;
    end
  end

  assign wr_o      = wr_q;
  assign wthread_o = out_q.thread;
  assign wa_o      = out_q.wa;
  assign wmask_o   = out_q.mask;
  assign o_o       = out_q.val;
  assign idle_o    = ~(|pending_o) & ~wr_q;

endmodule
